riscv_pipeline_core: RTL

RISCV_PIPELINE_CORE -- requirements
Module: riscv_pipeline_core

---
 rtl/riscv_pipeline_core.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/riscv_pipeline_core.sv
// ============================================================================
// Module   : riscv_pipeline_core
// Brief    : Five-stage in-order RV32 integer subset pipeline with forwarding
//            or interlock hazard handling and EX-stage branch resolution.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module riscv_pipeline_core #(
    parameter logic [31:0] RESET_VECTOR = 32'h00000000,
    parameter int          FORWARD_EN   = 1,
    parameter int          XLEN         = 32
) (
    input  logic            clk,
    input  logic            rst,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic            dmem_we,
    output logic            dmem_re,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            retire_valid,
    output logic [4:0]      retire_rd,
    output logic [XLEN-1:0] retire_data
);
    localparam bit       c_FWD      = (FORWARD_EN != 0);
    localparam logic [3:0] c_ALU_ADD = 4'd0, c_ALU_SUB = 4'd1, c_ALU_AND = 4'd2,
                           c_ALU_OR  = 4'd3, c_ALU_XOR = 4'd4, c_ALU_SLT = 4'd5,
                           c_ALU_SLL = 4'd6, c_ALU_SRL = 4'd7, c_ALU_SRA = 4'd8,
                           c_ALU_PASSB = 4'd9;
    localparam logic [6:0] c_OP_R = 7'b0110011, c_OP_I = 7'b0010011, c_OP_LUI = 7'b0110111,
                           c_OP_LW = 7'b0000011, c_OP_SW = 7'b0100011, c_OP_BR = 7'b1100011,
                           c_OP_JAL = 7'b1101111;

    logic [XLEN-1:0] r_regs [32];
    logic [XLEN-1:0] r_pc;
    logic            r_d_valid;
    logic [XLEN-1:0] r_d_pc;
    logic [31:0]     r_d_instr;
    logic            r_e_valid, r_e_src_imm, r_e_we, r_e_lw, r_e_sw, r_e_beq, r_e_bne, r_e_jal;
    logic [4:0]      r_e_rs1, r_e_rs2, r_e_rd;
    logic [3:0]      r_e_alu;
    logic [XLEN-1:0] r_e_pc, r_e_a, r_e_b, r_e_imm;
    logic            r_m_valid, r_m_we, r_m_lw, r_m_sw;
    logic [4:0]      r_m_rd;
    logic [XLEN-1:0] r_m_alu, r_m_store;
    logic            r_w_valid, r_w_we;
    logic [4:0]      r_w_rd;
    logic [XLEN-1:0] r_w_data;

    logic [6:0]      w_op;
    logic [2:0]      w_f3;
    logic [4:0]      w_rs1, w_rs2, w_rd;
    logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
    logic            w_dec_we, w_dec_src_imm, w_dec_lw, w_dec_sw, w_dec_beq, w_dec_bne, w_dec_jal;
    logic            w_use1, w_use2;
    logic [3:0]      w_dec_alu;
    logic [XLEN-1:0] w_dec_imm, w_rs1_val, w_rs2_val;
    logic            w_ex_hit, w_mem_hit, w_stall, w_taken;
    logic [XLEN-1:0] w_a, w_b_fwd, w_b, w_alu, w_ex_res, w_target;

    assign w_op  = r_d_instr[6:0];
    assign w_f3  = r_d_instr[14:12];
    assign w_rd  = r_d_instr[11:7];
    assign w_rs1 = r_d_instr[19:15];
    assign w_rs2 = r_d_instr[24:20];
    assign w_imm_i = XLEN'($signed(r_d_instr[31:20]));
    assign w_imm_s = XLEN'($signed({r_d_instr[31:25], r_d_instr[11:7]}));
    assign w_imm_b = XLEN'($signed({r_d_instr[31], r_d_instr[7], r_d_instr[30:25], r_d_instr[11:8], 1'b0}));
    assign w_imm_u = XLEN'($signed({r_d_instr[31:12], 12'b0}));
    assign w_imm_j = XLEN'($signed({r_d_instr[31], r_d_instr[19:12], r_d_instr[20], r_d_instr[30:21], 1'b0}));

    always_comb begin
        w_dec_we = 1'b0; w_dec_src_imm = 1'b0; w_dec_lw = 1'b0; w_dec_sw = 1'b0;
        w_dec_beq = 1'b0; w_dec_bne = 1'b0; w_dec_jal = 1'b0; w_use1 = 1'b0; w_use2 = 1'b0;
        w_dec_alu = c_ALU_ADD; w_dec_imm = w_imm_i;
        case (w_op)
            c_OP_R, c_OP_I: begin
                w_use1 = 1'b1;
                w_use2 = (w_op == c_OP_R);
                w_dec_src_imm = (w_op == c_OP_I);
                w_dec_we = 1'b1;
                case (w_f3)
                    3'b000:  w_dec_alu = (w_op == c_OP_R && r_d_instr[30]) ? c_ALU_SUB : c_ALU_ADD;
                    3'b001:  w_dec_alu = c_ALU_SLL;
                    3'b010:  w_dec_alu = c_ALU_SLT;
                    3'b100:  w_dec_alu = c_ALU_XOR;
                    3'b101:  w_dec_alu = r_d_instr[30] ? c_ALU_SRA : c_ALU_SRL;
                    3'b110:  w_dec_alu = c_ALU_OR;
                    3'b111:  w_dec_alu = c_ALU_AND;
                    default: w_dec_we = 1'b0;
                endcase
            end
            c_OP_LUI: begin
                w_dec_we = 1'b1; w_dec_src_imm = 1'b1; w_dec_imm = w_imm_u; w_dec_alu = c_ALU_PASSB;
            end
            c_OP_LW: if (w_f3 == 3'b010) begin
                w_use1 = 1'b1; w_dec_we = 1'b1; w_dec_src_imm = 1'b1; w_dec_lw = 1'b1;
            end
            c_OP_SW: if (w_f3 == 3'b010) begin
                w_use1 = 1'b1; w_use2 = 1'b1; w_dec_src_imm = 1'b1; w_dec_sw = 1'b1; w_dec_imm = w_imm_s;
            end
            c_OP_BR: if (w_f3[2:1] == 2'b00) begin
                w_use1 = 1'b1; w_use2 = 1'b1; w_dec_imm = w_imm_b;
                w_dec_beq = ~w_f3[0]; w_dec_bne = w_f3[0];
            end
            c_OP_JAL: begin
                w_dec_we = 1'b1; w_dec_jal = 1'b1; w_dec_imm = w_imm_j;
            end
            default: ;
        endcase
    end

    // WB write-through; x0 is never written so its array entry stays zero.
    assign w_rs1_val = (r_w_valid && r_w_we && r_w_rd == w_rs1) ? r_w_data : r_regs[w_rs1];
    assign w_rs2_val = (r_w_valid && r_w_we && r_w_rd == w_rs2) ? r_w_data : r_regs[w_rs2];

    assign w_ex_hit  = r_e_valid & r_e_we & ((w_use1 & (r_e_rd == w_rs1)) | (w_use2 & (r_e_rd == w_rs2)));
    assign w_mem_hit = r_m_valid & r_m_we & ((w_use1 & (r_m_rd == w_rs1)) | (w_use2 & (r_m_rd == w_rs2)));
    assign w_stall   = r_d_valid & (c_FWD ? (w_ex_hit & r_e_lw) : (w_ex_hit | w_mem_hit));

    assign w_a = (c_FWD && r_m_valid && r_m_we && r_m_rd == r_e_rs1) ? r_m_alu :
                 (c_FWD && r_w_valid && r_w_we && r_w_rd == r_e_rs1) ? r_w_data : r_e_a;
    assign w_b_fwd = (c_FWD && r_m_valid && r_m_we && r_m_rd == r_e_rs2) ? r_m_alu :
                     (c_FWD && r_w_valid && r_w_we && r_w_rd == r_e_rs2) ? r_w_data : r_e_b;
    assign w_b = r_e_src_imm ? r_e_imm : w_b_fwd;

    always_comb begin
        case (r_e_alu)
            c_ALU_ADD:   w_alu = w_a + w_b;
            c_ALU_SUB:   w_alu = w_a - w_b;
            c_ALU_AND:   w_alu = w_a & w_b;
            c_ALU_OR:    w_alu = w_a | w_b;
            c_ALU_XOR:   w_alu = w_a ^ w_b;
            c_ALU_SLT:   w_alu = XLEN'($signed(w_a) < $signed(w_b));
            c_ALU_SLL:   w_alu = w_a << w_b[4:0];
            c_ALU_SRL:   w_alu = w_a >> w_b[4:0];
            c_ALU_SRA:   w_alu = $signed(w_a) >>> w_b[4:0];
            c_ALU_PASSB: w_alu = w_b;
            default:     w_alu = '0;
        endcase
    end

    assign w_taken  = r_e_valid & (r_e_jal | (r_e_beq & (w_a == w_b_fwd)) | (r_e_bne & (w_a != w_b_fwd)));
    assign w_target = r_e_pc + r_e_imm;
    assign w_ex_res = r_e_jal ? (r_e_pc + XLEN'(4)) : w_alu;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) r_regs[i] <= '0;
        end else if (r_w_valid && r_w_we) begin
            r_regs[r_w_rd] <= r_w_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= XLEN'(RESET_VECTOR);
            r_d_valid <= 1'b0; r_e_valid <= 1'b0; r_m_valid <= 1'b0; r_w_valid <= 1'b0;
        end else begin
            r_w_valid <= r_m_valid;
            r_w_we    <= r_m_valid & r_m_we;
            r_w_rd    <= r_m_rd;
            r_w_data  <= r_m_lw ? dmem_rdata : r_m_alu;

            r_m_valid <= r_e_valid;
            r_m_we    <= r_e_valid & r_e_we;
            r_m_rd    <= r_e_rd;
            r_m_alu   <= w_ex_res;
            r_m_store <= w_b_fwd;
            r_m_lw    <= r_e_lw;
            r_m_sw    <= r_e_sw;

            // A taken branch wins over a stall: both younger stages are discarded.
            r_e_valid   <= r_d_valid & ~w_stall & ~w_taken;
            r_e_pc      <= r_d_pc;
            r_e_rs1     <= w_rs1;
            r_e_rs2     <= w_rs2;
            r_e_rd      <= w_rd;
            r_e_a       <= w_rs1_val;
            r_e_b       <= w_rs2_val;
            r_e_imm     <= w_dec_imm;
            r_e_alu     <= w_dec_alu;
            r_e_src_imm <= w_dec_src_imm;
            r_e_we      <= w_dec_we & (w_rd != 5'd0);
            r_e_lw      <= w_dec_lw;
            r_e_sw      <= w_dec_sw;
            r_e_beq     <= w_dec_beq;
            r_e_bne     <= w_dec_bne;
            r_e_jal     <= w_dec_jal;

            if (w_taken) begin
                r_pc      <= w_target;
                r_d_valid <= 1'b0;
            end else if (!w_stall) begin
                r_pc      <= r_pc + XLEN'(4);
                r_d_valid <= 1'b1;
                r_d_pc    <= r_pc;
                r_d_instr <= imem_rdata;
            end
        end
    end

    assign imem_addr    = r_pc;
    assign dmem_addr    = r_m_alu;
    assign dmem_wdata   = r_m_store;
    assign dmem_we      = ~rst & r_m_valid & r_m_sw;
    assign dmem_re      = ~rst & r_m_valid & r_m_lw;
    assign retire_valid = ~rst & r_w_valid;
    assign retire_rd    = (~rst & r_w_valid & r_w_we) ? r_w_rd : 5'd0;
    assign retire_data  = (~rst & r_w_valid & r_w_we) ? r_w_data : '0;

endmodule

`default_nettype wire
